hbridge_pwm_array: RTL

HBRIDGE_PWM_ARRAY -- requirements
Module: hbridge_pwm_array

---
 rtl/hbridge_pwm_array_if.sv | 26 ++
 rtl/hbridge_pwm_array.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hbridge_pwm_array_if.sv
// Command channel for hbridge_pwm_array: valid/ready handshake carrying
// target channel, mode bits and duty value.
interface hbridge_pwm_array_if #(
  parameter int NUM_CH = 4,
  parameter int DUTY_W = 5
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_on;
  logic              cmd_dir;
  logic              cmd_brake;
  logic [DUTY_W-1:0] cmd_duty;

  modport master (
    output cmd_valid, cmd_ch, cmd_on, cmd_dir, cmd_brake, cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_on, cmd_dir, cmd_brake, cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/hbridge_pwm_array.sv
// hbridge_pwm_array: NUM_CH H-bridge gate drivers sharing one free-running
// PWM counter. Commands land in a per-channel shadow register and are
// activated together at the period boundary (counter all-ones). Any change
// between two driving modes passes through DEAD_TIME all-low cycles.
// Optional feature: define MOTOR_RAMP_EN to slew the active duty by one LSB
// per period toward the commanded duty.
//
// state    | meaning
// ST_IDLE  | bridge off, all gates low
// ST_DEAD  | mode change in progress, gates low for DEAD_TIME cycles
// ST_DRIVE | gates follow the PWM of the active mode and duty
module hbridge_pwm_array #(
  parameter int NUM_CH    = 4,
  parameter int DUTY_W    = 5,
  parameter int DEAD_TIME = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  hbridge_pwm_array_if.slave  cmd,
  output logic [4*NUM_CH-1:0] out,
  output logic [NUM_CH-1:0]   busy
);
  localparam int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_TIME - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DEAD, ST_DRIVE} state_t;
  typedef enum logic [1:0] {M_OFF, M_BRAKE, M_FWD, M_REV} mode_t;

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  mode_t             shd_mode_q [NUM_CH];
  mode_t             shd_mode_d [NUM_CH];
  logic [DUTY_W-1:0] shd_duty_q [NUM_CH];
  logic [DUTY_W-1:0] shd_duty_d [NUM_CH];
  mode_t             act_mode_q [NUM_CH];
  mode_t             act_mode_d [NUM_CH];
  logic [DUTY_W-1:0] duty_q     [NUM_CH];
  logic [DUTY_W-1:0] duty_d     [NUM_CH];
  state_t            state_q    [NUM_CH];
  state_t            state_d    [NUM_CH];
  logic [15:0]       dead_q     [NUM_CH];
  logic [15:0]       dead_d     [NUM_CH];
  logic [4*NUM_CH-1:0] out_q, out_d;
`ifdef MOTOR_RAMP_EN
  logic [DUTY_W-1:0] ramp_q     [NUM_CH];
  logic [DUTY_W-1:0] ramp_d     [NUM_CH];
`endif

  logic  boundary;
  logic  cmd_fire;
  logic  cmd_ready_c;
  mode_t cmd_mode;

  function automatic logic [3:0] pattern(input mode_t m);
    case (m)
      M_BRAKE: return 4'b0011;
      M_FWD:   return 4'b1001;
      M_REV:   return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  // Decode the command mode bits; brake overrides direction.
  always_comb begin
    cmd_mode = M_OFF;
    if (cmd.cmd_on) begin
      if (cmd.cmd_brake)    cmd_mode = M_BRAKE;
      else if (cmd.cmd_dir) cmd_mode = M_FWD;
      else                  cmd_mode = M_REV;
    end
  end

  // Ready unless the addressed channel already holds a pending command;
  // out-of-range channels never match and are always accepted (and dropped).
  always_comb begin
    cmd_ready_c = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cmd.cmd_ch == CH_W'(k)) cmd_ready_c = !pending_q[k];
    end
  end

  assign cmd.cmd_ready = cmd_ready_c;
  assign cmd_fire      = cmd.cmd_valid && cmd_ready_c;
  assign boundary      = &cnt_q;
  assign out           = out_q;

  // Next-state for counter, shadow/active registers, channel FSMs and outputs.
  always_comb begin
    cnt_d     = cnt_q + DUTY_W'(1);
    pending_d = pending_q;
    out_d     = '0;
    busy      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      shd_mode_d[k] = shd_mode_q[k];
      shd_duty_d[k] = shd_duty_q[k];
      act_mode_d[k] = act_mode_q[k];
      duty_d[k]     = duty_q[k];
      state_d[k]    = state_q[k];
      dead_d[k]     = dead_q[k];

      if (state_q[k] == ST_DEAD) begin
        if (dead_q[k] == DEAD_LAST) state_d[k] = ST_DRIVE;
        else                        dead_d[k]  = dead_q[k] + 16'd1;
      end

      // Activation overrides dead-time progress; same mode keeps the state.
      if (boundary && pending_q[k]) begin
        pending_d[k]  = 1'b0;
        act_mode_d[k] = shd_mode_q[k];
        duty_d[k]     = shd_duty_q[k];
        if (shd_mode_q[k] == M_OFF) begin
          state_d[k] = ST_IDLE;
        end else if (shd_mode_q[k] != act_mode_q[k]) begin
          state_d[k] = ST_DEAD;
          dead_d[k]  = '0;
        end
      end

      // Pending is clear whenever a transfer is possible, so no clash with
      // the boundary clear above.
      if (cmd_fire && (cmd.cmd_ch == CH_W'(k))) begin
        pending_d[k]  = 1'b1;
        shd_mode_d[k] = cmd_mode;
        shd_duty_d[k] = cmd.cmd_duty;
      end

`ifdef MOTOR_RAMP_EN
      ramp_d[k] = ramp_q[k];
      if (state_q[k] == ST_DEAD && state_d[k] == ST_DRIVE) begin
        ramp_d[k] = '0;
      end else if (boundary && state_q[k] == ST_DRIVE && state_d[k] == ST_DRIVE) begin
        if (ramp_q[k] < duty_d[k])      ramp_d[k] = ramp_q[k] + DUTY_W'(1);
        else if (ramp_q[k] > duty_d[k]) ramp_d[k] = ramp_q[k] - DUTY_W'(1);
      end
      out_d[4*k +: 4] = (state_q[k] == ST_DRIVE && cnt_q < ramp_q[k]) ?
                        pattern(act_mode_q[k]) : 4'b0000;
`else
      out_d[4*k +: 4] = (state_q[k] == ST_DRIVE && cnt_q < duty_q[k]) ?
                        pattern(act_mode_q[k]) : 4'b0000;
`endif

      busy[k] = pending_q[k] || (state_q[k] == ST_DEAD);
    end
  end

  // State registers; reset clears everything, including out, asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= '0;
      out_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shd_mode_q[k] <= M_OFF;
        shd_duty_q[k] <= '0;
        act_mode_q[k] <= M_OFF;
        duty_q[k]     <= '0;
        state_q[k]    <= ST_IDLE;
        dead_q[k]     <= '0;
`ifdef MOTOR_RAMP_EN
        ramp_q[k]     <= '0;
`endif
      end
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      for (int k = 0; k < NUM_CH; k++) begin
        shd_mode_q[k] <= shd_mode_d[k];
        shd_duty_q[k] <= shd_duty_d[k];
        act_mode_q[k] <= act_mode_d[k];
        duty_q[k]     <= duty_d[k];
        state_q[k]    <= state_d[k];
        dead_q[k]     <= dead_d[k];
`ifdef MOTOR_RAMP_EN
        ramp_q[k]     <= ramp_d[k];
`endif
      end
    end
  end
endmodule
